bank_fill_dma: RTL

Streams a full image out of the coprocessor's image buffer into the three line banks, one pixel per cycle. Image row r is written to bank (r mod 3) at bank row address (r div 3), so the kernel-side read DMA always finds rows r-1, r and r+1 in three different banks. It sits between the image buffer read port and the three bank write ports. The CPU-side control register starts it, and the read-side DMA is started only after this block reports done.

---
 rtl/bank_fill_dma.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bank_fill_dma.sv
// bank_fill_dma
// Streams a whole image from the image buffer into three line banks, one
// pixel per cycle. Image row r goes to bank (r mod 3) at bank row (r div 3).
// This lets the kernel-side reader find rows r-1, r and r+1 in three
// different banks.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start, abort  control (abort wins); busy, done status
//   src_*         image buffer read port (1-cycle read latency)
//   bank_*        shared write port to the three banks, one-hot bank_we
module bank_fill_dma #(
  parameter int COLS       = 256,   // power of two
  parameter int ROWS       = 384,   // 3*BANK_DEPTH
  parameter int BANK_DEPTH = 128,
  parameter int PIX_W      = 8,
  localparam int AW = $clog2(ROWS*COLS),
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS),
  localparam int BW = $clog2(BANK_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic             src_ready,
  output logic             src_re,
  output logic [AW-1:0]    src_addr,
  input  logic             src_rvalid,
  input  logic [PIX_W-1:0] src_rdata,
  output logic [2:0]       bank_we,
  output logic [BW-1:0]    bank_waddr,
  output logic [CW-1:0]    bank_wcol,
  output logic [PIX_W-1:0] bank_wdata
);

  localparam logic [CW-1:0] LAST_COL = CW'(COLS-1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state;
  logic [CW-1:0]  rd_col, wr_col;
  logic [RW-1:0]  rd_row, wr_row;
  logic [BW-1:0]  wr_bank_row;   // wr_row div 3, kept as a counter
  logic [2:0]     wr_sel;
  logic           outstanding;

  logic fill_go, active, kill, rd_fire, rd_last, wr_fire, wr_last;

  assign fill_go = (state == S_IDLE) & start & ~abort;
  assign active  = (state == S_RUN) | (state == S_DRAIN);
  // An abort drops whatever returns in its own cycle. The return in the
  // next cycle is also dropped, because the abort clears outstanding.
  assign kill    = abort & active;
  assign rd_fire = src_re;
  assign rd_last = rd_fire & (rd_row == LAST_ROW) & (rd_col == LAST_COL);
  assign wr_fire = src_rvalid & outstanding & ~kill;
  assign wr_last = wr_fire & (wr_row == LAST_ROW) & (wr_col == LAST_COL);

  assign src_re     = src_ready & (state == S_RUN);
  // Read counters are cleared outside a fill, so the address rests at 0.
  assign src_addr   = AW'({rd_row, rd_col});
  assign bank_we    = wr_sel & {3{wr_fire}};
  assign bank_waddr = wr_bank_row;
  assign bank_wcol  = wr_col;
  assign bank_wdata = src_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (fill_go) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (rd_last) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (wr_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Single-deep tracker: with exactly one cycle of latency, a return is
  // ours only if the previous cycle issued an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) outstanding <= 1'b0;
    else     outstanding <= src_re & ~abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_col <= '0;
      rd_row <= '0;
    end else if (fill_go || kill || rd_last) begin
      rd_col <= '0;
      rd_row <= '0;
    end else if (rd_fire) begin
      if (rd_col == LAST_COL) begin
        rd_col <= '0;
        rd_row <= rd_row + 1'b1;
      end else begin
        rd_col <= rd_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_col      <= '0;
      wr_row      <= '0;
      wr_bank_row <= '0;
      wr_sel      <= 3'b001;
    end else if (fill_go || kill || wr_last) begin
      wr_col      <= '0;
      wr_row      <= '0;
      wr_bank_row <= '0;
      wr_sel      <= 3'b001;
    end else if (wr_fire) begin
      if (wr_col == LAST_COL) begin
        wr_col <= '0;
        wr_row <= wr_row + 1'b1;
        wr_sel <= {wr_sel[1:0], wr_sel[2]};
        // Bank row advances once every three image rows.
        if (wr_sel[2]) wr_bank_row <= wr_bank_row + 1'b1;
      end else begin
        wr_col <= wr_col + 1'b1;
      end
    end
  end

endmodule
